// File: rtl/groestl_mm_bridge_if.sv
// groestl_mm_bridge_if: Avalon-MM slave bus plus core-side message/digest stream.
// Signals:
//   address, writedata, byteenable, write, read, chipselect, readdata, irq
//     form the CPU-facing Avalon-MM slave port.
//   core_data, core_last, core_valid, core_ready, core_digest, core_done
//     form the Groestl core link.
// Modports:
//   slave  - the bridge's view of these signals.
//   master - the environment's view (CPU plus hash core).
interface groestl_mm_bridge_if #(
    parameter int DIGEST_WORDS = 8
);
    logic [4:0]                 address;
    logic [31:0]                writedata;
    logic [3:0]                 byteenable;
    logic                       write;
    logic                       read;
    logic                       chipselect;
    logic [31:0]                readdata;
    logic                       irq;
    logic [31:0]                core_data;
    logic                       core_last;
    logic                       core_valid;
    logic                       core_ready;
    logic [DIGEST_WORDS*32-1:0] core_digest;
    logic                       core_done;

    modport slave (
        input  address, writedata, byteenable, write, read, chipselect,
        input  core_ready, core_digest, core_done,
        output readdata, irq, core_data, core_last, core_valid
    );

    modport master (
        output address, writedata, byteenable, write, read, chipselect,
        output core_ready, core_digest, core_done,
        input  readdata, irq, core_data, core_last, core_valid
    );
endinterface

// File: rtl/groestl_mm_bridge.sv
// groestl_mm_bridge: Avalon-MM front-end that queues message words in a FIFO
// and streams them to a Groestl core, then captures the returned digest.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   bus   - groestl_mm_bridge_if.slave (Avalon-MM slave plus core stream)
// Parameters:
//   FIFO_DEPTH   - power of two, 2..16
//   DIGEST_WORDS - 1..16
// Optional feature: define GROESTL_MM_IRQ_EN to implement IRQ_EN and a registered irq.
module groestl_mm_bridge #(
    parameter int FIFO_DEPTH   = 16,
    parameter int DIGEST_WORDS = 8
) (
    input logic                clk,
    input logic                reset,
    groestl_mm_bridge_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

    state_t        state, state_next;
    logic [32:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic [15:0]   remaining;
    logic          hash_ready, overflow, irq_en_bit;
    // Sized for the maximum digest; unused words stay zero, so reads beyond
    // DIGEST_WORDS naturally return 0.
    logic [31:0]   digest [16];
    logic          wr, rd_req, len_wr, data_wr, clr_wr, arm, done_ok;
    logic          full, empty, push, pop;
    logic [31:0]   data_masked, rd_val;

    assign wr      = bus.chipselect & bus.write;
    assign rd_req  = bus.chipselect & bus.read;
    assign len_wr  = wr && bus.address == 5'h00;
    assign data_wr = wr && bus.address == 5'h01;
    assign clr_wr  = wr && bus.address == 5'h04;
    assign arm     = len_wr && state == IDLE && bus.writedata[15:0] != 16'd0;
    assign done_ok = bus.core_done && state == WAIT;
    assign full    = level == (AW+1)'(FIFO_DEPTH);
    assign empty   = level == '0;
    assign push    = data_wr && state == LOAD && !full;
    assign pop     = bus.core_valid && bus.core_ready;

    // The head entry is held in flops and only moves on a pop, so it is stable
    // while the core stalls; it is gated to zero when the FIFO is empty.
    assign bus.core_valid = !empty;
    assign {bus.core_last, bus.core_data} = empty ? 33'd0 : mem[rd_ptr];

    always_comb begin
        data_masked = 32'd0;
        for (int i = 0; i < 4; i++)
            data_masked[8*i +: 8] = bus.byteenable[i] ? bus.writedata[8*i +: 8] : 8'h00;
    end

    always_comb begin
        state_next = state;
        if (arm)
            state_next = LOAD;
        else if (push && remaining == 16'd1)
            state_next = WAIT;
        else if (done_ok)
            state_next = IDLE;
    end

    always_comb begin
        rd_val = 32'd0;
        if (bus.address == 5'h00)
            rd_val = {16'd0, remaining};
        else if (bus.address == 5'h02)
            rd_val = {19'd0, 5'(level), 3'd0, overflow, empty, full, hash_ready, state != IDLE};
        else if (bus.address == 5'h05)
            rd_val = {31'd0, irq_en_bit};
        else if (bus.address[4])
            rd_val = digest[bus.address[3:0]];
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {remaining == 16'd1, data_masked};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            remaining    <= 16'd0;
            hash_ready   <= 1'b0;
            overflow     <= 1'b0;
            bus.readdata <= 32'd0;
            for (int i = 0; i < 16; i++)
                digest[i] <= 32'd0;
        end else begin
            state  <= state_next;
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            level  <= level + (AW+1)'(push) - (AW+1)'(pop);
            if (arm)
                remaining <= bus.writedata[15:0];
            else if (push)
                remaining <= remaining - 16'd1;
            // A dropped DATA write can never coincide with CLEAR (different addresses).
            if (data_wr && !push)
                overflow <= 1'b1;
            else if (clr_wr)
                overflow <= 1'b0;
            // core_done wins over CLEAR so a digest landing in that cycle is not lost.
            if (done_ok) begin
                hash_ready <= 1'b1;
                for (int i = 0; i < DIGEST_WORDS; i++)
                    digest[i] <= bus.core_digest[(DIGEST_WORDS-1-i)*32 +: 32];
            end else if (clr_wr) begin
                hash_ready <= 1'b0;
            end
            if (rd_req)
                bus.readdata <= rd_val;
        end
    end

`ifdef GROESTL_MM_IRQ_EN
    logic irq_en;

    assign irq_en_bit = irq_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en  <= 1'b0;
            bus.irq <= 1'b0;
        end else begin
            if (wr && bus.address == 5'h05)
                irq_en <= bus.writedata[0];
            bus.irq <= hash_ready & irq_en;
        end
    end
`else
    assign irq_en_bit = 1'b0;
    assign bus.irq    = 1'b0;
`endif
endmodule

// File: tb/tb_groestl_mm_bridge.sv
// tb_groestl_mm_bridge: directed self-checking bench for groestl_mm_bridge
// (FIFO_DEPTH=4, DIGEST_WORDS=8). Follows GROESTL_MM_IRQ_EN for irq expectations.
module tb_groestl_mm_bridge;
`ifdef GROESTL_MM_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] rd;

    groestl_mm_bridge_if #(.DIGEST_WORDS(8)) bus ();

    groestl_mm_bridge #(.FIFO_DEPTH(4), .DIGEST_WORDS(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = a;
        bus.writedata  = d;
        bus.byteenable = be;
        cyc();
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = a;
        cyc();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        d = bus.readdata;
    endtask

    task automatic set_digest(input logic [31:0] base);
        for (int i = 0; i < 8; i++)
            bus.core_digest[(7-i)*32 +: 32] = base + 32'(i);
    endtask

    initial begin
        bus.address = '0; bus.writedata = '0; bus.byteenable = '0;
        bus.write = 0; bus.read = 0; bus.chipselect = 0;
        bus.core_ready = 0; bus.core_digest = '0; bus.core_done = 0;
        repeat (10) cyc();
        reset = 1'b0;

        // Reset state
        chk("rst_valid", bus.core_valid, 0);
        chk("rst_data", bus.core_data, 0);
        chk("rst_irq", bus.irq, 0);
        chk("rst_readdata", bus.readdata, 0);
        bus_read(5'h02, rd); chk("rst_status", rd, 32'h8);

        // Two-word message with the core always ready
        bus.core_ready = 1;
        bus_write(5'h00, 32'd2, 4'hF);
        bus_write(5'h01, 32'h80000000, 4'hF);
        chk("m1_valid0", bus.core_valid, 1);
        chk("m1_data0", bus.core_data, 32'h80000000);
        chk("m1_last0", bus.core_last, 0);
        bus_write(5'h01, 32'hCC000000, 4'hF);
        chk("m1_data1", bus.core_data, 32'hCC000000);
        chk("m1_last1", bus.core_last, 1);
        bus_read(5'h02, rd); chk("m1_status_wait", rd, 32'h101);
        chk("m1_drained", bus.core_valid, 0);
        set_digest(32'h0);
        bus.core_digest = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                           32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        bus.core_done = 1; cyc(); bus.core_done = 0;
        bus_read(5'h02, rd); chk("m1_status_done", rd, 32'h0A);
        bus_read(5'h10, rd); chk("m1_dig0", rd, 32'h11111111);
        bus_read(5'h13, rd); chk("m1_dig3", rd, 32'h44444444);
        bus_read(5'h17, rd); chk("m1_dig7", rd, 32'h88888888);
        bus_read(5'h18, rd); chk("unmapped_dig8", rd, 32'h0);
        bus_read(5'h03, rd); chk("unmapped_3", rd, 32'h0);
        bus_write(5'h04, 32'h0, 4'hF);
        bus_read(5'h02, rd); chk("clear_status", rd, 32'h8);

        // Overflow with a stalled core
        bus.core_ready = 0;
        bus_write(5'h00, 32'd6, 4'hF);
        for (int i = 1; i <= 6; i++) bus_write(5'h01, 32'h1000 + 32'(i), 4'hF);
        bus_read(5'h02, rd); chk("ovf_status", rd, 32'h415);
        bus_read(5'h00, rd); chk("ovf_len", rd, 32'd2);
        chk("ovf_head", bus.core_data, 32'h1001);
        bus.core_ready = 1;
        cyc(); chk("drain_next", bus.core_data, 32'h1002);
        repeat (3) cyc(); chk("drain_empty", bus.core_valid, 0);
        bus.core_ready = 0;
        bus_write(5'h01, 32'hAABBCCDD, 4'b0011);
        chk("be_data", bus.core_data, 32'h0000CCDD);
        chk("be_last", bus.core_last, 0);
        bus_write(5'h01, 32'h12345678, 4'b1100);
        chk("stall_hold", bus.core_data, 32'h0000CCDD);
        bus_read(5'h02, rd); chk("wait_status", rd, 32'h211);
        bus_write(5'h00, 32'd5, 4'hF);
        bus_read(5'h00, rd); chk("len_ignored_wait", rd, 32'd0);
        bus.core_ready = 1;
        cyc();
        chk("be_hi_data", bus.core_data, 32'h12340000);
        chk("be_hi_last", bus.core_last, 1);
        cyc(); chk("wait_drained", bus.core_valid, 0);

        // Interrupt behaviour
        bus_write(5'h04, 32'h0, 4'hF);
        bus_write(5'h05, 32'h1, 4'hF);
        bus_read(5'h05, rd); chk("irq_en_rd", rd, {31'd0, IRQ_ON});
        set_digest(32'hA0A0A0A0);
        bus.core_done = 1; cyc(); bus.core_done = 0;
        chk("irq_not_yet", bus.irq, 0);
        cyc(); chk("irq_set", bus.irq, {31'd0, IRQ_ON});
        bus_write(5'h04, 32'h0, 4'hF);
        chk("irq_hold_clear", bus.irq, {31'd0, IRQ_ON});
        cyc(); chk("irq_cleared", bus.irq, 0);
        bus_read(5'h10, rd); chk("m2_dig0", rd, 32'hA0A0A0A0);
        bus_read(5'h17, rd); chk("m2_dig7", rd, 32'hA0A0A0A7);

        // core_done in IDLE is ignored
        bus.core_digest = '1;
        bus.core_done = 1; cyc(); bus.core_done = 0;
        bus_read(5'h02, rd); chk("idle_done_status", rd, 32'h8);
        bus_read(5'h10, rd); chk("idle_done_dig", rd, 32'hA0A0A0A0);

        // Overflow in WAIT, then CLEAR coinciding with core_done
        bus_write(5'h00, 32'd1, 4'hF);
        bus_write(5'h01, 32'h55, 4'hF);
        bus_write(5'h01, 32'h66, 4'hF);
        bus_read(5'h02, rd); chk("wait_ovf_status", rd, 32'h19);
        set_digest(32'hB0000000);
        bus.core_done = 1;
        bus_write(5'h04, 32'h0, 4'hF);
        bus.core_done = 0;
        bus_read(5'h02, rd); chk("clr_done_status", rd, 32'h0A);

        // core_done while hash_ready is already set overwrites the digest
        bus_write(5'h00, 32'd1, 4'hF);
        bus_write(5'h01, 32'h77, 4'hF);
        set_digest(32'hC0000000);
        bus.core_done = 1; cyc(); bus.core_done = 0;
        bus_read(5'h02, rd); chk("redo_status", rd, 32'h0A);
        bus_read(5'h11, rd); chk("redo_dig1", rd, 32'hC0000001);

        // Reset in WAIT with three words queued
        bus.core_ready = 0;
        bus_write(5'h00, 32'd3, 4'hF);
        for (int i = 0; i < 3; i++) bus_write(5'h01, 32'hD0 + 32'(i), 4'hF);
        bus_read(5'h02, rd); chk("pre_reset_status", rd, 32'h303);
        reset = 1; cyc(); cyc(); reset = 0;
        chk("post_rst_valid", bus.core_valid, 0);
        chk("post_rst_data", bus.core_data, 0);
        chk("post_rst_irq", bus.irq, 0);
        chk("post_rst_readdata", bus.readdata, 0);
        bus_read(5'h02, rd); chk("post_rst_status", rd, 32'h8);
        bus_read(5'h10, rd); chk("post_rst_dig", rd, 32'h0);
        bus_read(5'h05, rd); chk("post_rst_irq_en", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
